// File: rtl/plot_sink_if.sv
// Pixel plot request channel and framebuffer write port, bundled for plot_sink.
interface plot_sink_if;
  logic        plot_valid;
  logic        plot_ready;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        fb_wr_en;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_busy;

  modport master (
    output plot_valid, x, y, colour, fb_busy,
    input  plot_ready, fb_wr_en, fb_addr, fb_data
  );

  modport slave (
    input  plot_valid, x, y, colour, fb_busy,
    output plot_ready, fb_wr_en, fb_addr, fb_data
  );
endinterface

// File: rtl/plot_sink.sv
// Plot request sink: range check, linear address, small FIFO, then a registered framebuffer write stage.
// state   | meaning
// S_EMPTY | output register holds nothing, fb_wr_en low
// S_WRITE | output register holds a write, fb_wr_en high until fb_busy allows completion
module plot_sink #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int DEPTH  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  plot_sink_if.slave  bus,
  output logic [7:0]  o_drop_count,
  output logic        o_idle
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_L   = CW'(DEPTH);
  localparam logic [7:0]    WIDTH_L  = 8'(WIDTH);
  localparam logic [6:0]    HEIGHT_L = 7'(HEIGHT);
  localparam logic [14:0]   WIDTH_A  = 15'(WIDTH);

  typedef enum logic {S_EMPTY, S_WRITE} state_t;

  state_t        r_state, w_state_nxt;
  logic [17:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_occ;
  logic [14:0]   r_addr;
  logic [2:0]    r_data;
  logic [7:0]    r_drop;
  logic          w_full, w_empty, w_accept, w_in_range, w_push, w_pop, w_drop;
  logic [14:0]   w_addr;

  assign w_full     = (r_occ == FULL_L);
  assign w_empty    = (r_occ == '0);
  assign w_accept   = bus.plot_valid && !w_full;
  assign w_in_range = (bus.x < WIDTH_L) && (bus.y < HEIGHT_L);
  assign w_push     = w_accept && w_in_range;
  assign w_drop     = w_accept && !w_in_range;
  assign w_addr     = 15'(bus.y) * WIDTH_A + 15'(bus.x);

  // storage has no reset; only pointers and occupancy define validity
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_addr, bus.colour};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_state  <= S_EMPTY;
      r_addr   <= '0;
      r_data   <= '0;
      r_drop   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) begin
        r_rd_ptr         <= r_rd_ptr + PW'(1);
        {r_addr, r_data} <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!bus.fb_busy) begin
          if (!w_empty) w_pop = 1'b1;
          else          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  assign bus.plot_ready = !w_full;
  assign bus.fb_wr_en   = (r_state == S_WRITE);
  assign bus.fb_addr    = r_addr;
  assign bus.fb_data    = r_data;
  assign o_drop_count   = r_drop;
  assign o_idle         = (r_state == S_EMPTY) && w_empty;
endmodule

// File: tb/tb_plot_sink.sv
// Self-checking bench for plot_sink: vector table, hand sequences and a randomized run against a queue model.
module tb_plot_sink;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] drop;
  logic       idle;

  always #5 clk = ~clk;

  plot_sink_if bus();

  plot_sink u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .bus          (bus),
    .o_drop_count (drop),
    .o_idle       (idle)
  );

  typedef struct {int addr; int col;} ent_t;
  typedef struct {int x; int y; int c; int on; int addr;} vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t q[$];
  int   m_ov   = 0;
  int   m_drop = 0;
  int   m_acc  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_ov   = 0;
    m_drop = 0;
    m_acc  = 0;
  endfunction

  // One rising edge of the sink described at the request level.
  function automatic void model_edge();
    int fifo;
    int ov_n;
    int xx, yy;
    fifo  = q.size() - m_ov;
    m_acc = (bus.plot_valid && (fifo < 4)) ? 1 : 0;
    if (m_ov != 0 && bus.fb_busy) ov_n = 1;
    else                          ov_n = (fifo > 0) ? 1 : 0;
    if (m_ov != 0 && !bus.fb_busy) void'(q.pop_front());
    m_ov = ov_n;
    if (m_acc != 0) begin
      xx = int'(bus.x);
      yy = int'(bus.y);
      if (xx < 160 && yy < 120) q.push_back('{yy * 160 + xx, int'(bus.colour)});
      else if (m_drop < 255)    m_drop++;
    end
  endfunction

  task automatic check_all();
    chk("plot_ready", int'(bus.plot_ready), ((q.size() - m_ov) < 4) ? 1 : 0);
    chk("fb_wr_en", int'(bus.fb_wr_en), m_ov);
    if (m_ov != 0) begin
      chk("fb_addr", int'(bus.fb_addr), q[0].addr);
      chk("fb_data", int'(bus.fb_data), q[0].col);
    end
    chk("idle", int'(idle), (q.size() == 0) ? 1 : 0);
    chk("drop_count", int'(drop), m_drop);
  endtask

  // Called at a falling edge: drive, take the rising edge, check at the next falling edge.
  task automatic step(input int v, input int xx, input int yy, input int cc, input int busy);
    bus.plot_valid = (v != 0);
    bus.x          = 8'(xx);
    bus.y          = 7'(yy);
    bus.colour     = 3'(cc);
    bus.fb_busy    = (busy != 0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int   exp_drop;
    int   got[$];
    int   acc5;
    int   wr_cnt, rdy_drop;

    vt[0] = '{3,   2,   5, 1, 323};
    vt[1] = '{0,   0,   1, 1, 0};
    vt[2] = '{159, 119, 7, 1, 19199};
    vt[3] = '{159, 0,   2, 1, 159};
    vt[4] = '{0,   1,   6, 1, 160};
    vt[5] = '{160, 0,   3, 0, 0};
    vt[6] = '{0,   120, 4, 0, 0};
    vt[7] = '{255, 127, 1, 0, 0};

    rst_n          = 1'b0;
    bus.plot_valid = 1'b0;
    bus.x          = '0;
    bus.y          = '0;
    bus.colour     = '0;
    bus.fb_busy    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_plot_ready", int'(bus.plot_ready), 1);
    chk("reset_idle", int'(idle), 1);
    chk("reset_fb_wr_en", int'(bus.fb_wr_en), 0);
    chk("reset_fb_addr", int'(bus.fb_addr), 0);
    chk("reset_fb_data", int'(bus.fb_data), 0);
    chk("reset_drop", int'(drop), 0);
    rst_n = 1'b1;

    // Vector table: each request isolated, one write cycle or none
    exp_drop = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, vt[i].x, vt[i].y, vt[i].c, 0);
      step(0, 0, 0, 0, 0);
      chk("vec_wr_en", int'(bus.fb_wr_en), vt[i].on);
      if (vt[i].on != 0) begin
        chk("vec_addr", int'(bus.fb_addr), vt[i].addr);
        chk("vec_data", int'(bus.fb_data), vt[i].c);
      end else begin
        exp_drop++;
      end
      step(0, 0, 0, 0, 0);
      chk("vec_wr_done", int'(bus.fb_wr_en), 0);
      chk("vec_idle", int'(idle), 1);
    end
    chk("vec_drop_total", int'(drop), exp_drop);

    // Saturation of the drop counter
    for (int i = 0; i < 300; i++) step(1, 200, 5, 0, 0);
    chk("drop_saturated", int'(drop), 255);
    for (int i = 0; i < 5; i++) step(1, 0, 125, 0, 0);
    chk("drop_held", int'(drop), 255);
    chk("drop_no_write", int'(bus.fb_wr_en), 0);

    // Stall: output register plus four FIFO entries, sixth request waits
    for (int i = 0; i < 5; i++) step(1, 10 + i, 20, i, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, 15, 20, 5, 1);
      chk("stall_ready_low", int'(bus.plot_ready), 0);
      chk("stall_addr_stable", int'(bus.fb_addr), 3210);
      chk("stall_wr_en", int'(bus.fb_wr_en), 1);
    end
    got.delete();
    acc5 = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.fb_wr_en) got.push_back(int'(bus.fb_addr));
      step((acc5 == 0) ? 1 : 0, 15, 20, 5, 0);
      if (m_acc != 0) acc5 = 1;
    end
    chk("stall_sixth_accepted", acc5, 1);
    chk("stall_write_count", got.size(), 6);
    for (int k = 0; k < 6 && k < got.size(); k++) chk("stall_order", got[k], 3210 + k);

    // Back-to-back stream
    wr_cnt   = 0;
    rdy_drop = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, $urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7), 0);
      if (!bus.plot_ready) rdy_drop++;
      if (bus.fb_wr_en) wr_cnt++;
    end
    step(0, 0, 0, 0, 0);
    if (bus.fb_wr_en) wr_cnt++;
    chk("stream_writes", wr_cnt, 20);
    chk("stream_ready_drops", rdy_drop, 0);
    step(0, 0, 0, 0, 0);
    chk("stream_idle", int'(idle), 1);

    // Asynchronous reset with three entries buffered and a stalled write
    for (int i = 0; i < 4; i++) step(1, 40 + i, 50, i + 1, 1);
    chk("pre_reset_wr_en", int'(bus.fb_wr_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_wr_en", int'(bus.fb_wr_en), 0);
    chk("async_reset_idle", int'(idle), 1);
    chk("async_reset_ready", int'(bus.plot_ready), 1);
    chk("async_reset_addr", int'(bus.fb_addr), 0);
    model_reset();
    bus.plot_valid = 1'b0;
    bus.fb_busy    = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    wr_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0);
      if (bus.fb_wr_en) wr_cnt++;
    end
    chk("no_stale_writes", wr_cnt, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 175),
           $urandom_range(0, 127), $urandom_range(0, 7),
           ($urandom_range(0, 3) == 0) ? 1 : 0);
    for (int i = 0; i < 20 && q.size() != 0; i++) step(0, 0, 0, 0, 0);
    chk("final_idle", int'(idle), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/plot_sink.md
# plot_sink

Receiving end of the pixel plot interface: accepts plot requests (x, y, colour) from a coordinate generator with a valid/ready handshake. It buffers them in a small FIFO, discards off-screen coordinates, and turns the rest into linear-address writes on the framebuffer write port. It sits between the drawing logic and the on-chip framebuffer memory.

## Interface
- WIDTH, 160, visible columns; legal x is 0..WIDTH-1
- HEIGHT, 120, visible rows; legal y is 0..HEIGHT-1
- DEPTH, 4, FIFO entries; must be a power of two, at least 2
- clk  input  1  sole clock; all logic is on its rising edge
- reset  input  1  asynchronous, active-low reset
- plot_valid  input  1  request present on x/y/colour
- plot_ready  output  1  sink can accept a request this cycle
- x  input  8  column
- y  input  7  row
- colour  input  3  pixel colour
- fb_wr_en  output  1  framebuffer write request
- fb_addr  output  15  linear pixel address
- fb_data  output  3  pixel colour to write
- fb_busy  input  1  framebuffer stall; a write completes only in a cycle with fb_wr_en=1 and fb_busy=0
- drop_count  output  8  count of off-screen requests, saturating
- idle  output  1  FIFO empty and no write pending

## Operation
- Accept rule: a request is accepted at a rising edge where plot_valid=1 and plot_ready=1.
  - plot_ready = !full, decoded from registered FIFO occupancy.
  - When the FIFO is full, a pop in the same cycle does not raise plot_ready; the push is refused that cycle.
- Range check happens at accept.
  - If x>=WIDTH or y>=HEIGHT, the request is consumed but not written into the FIFO.
  - drop_count increments, saturating at 255.
- Address is computed at push: addr = y*WIDTH + x, 15 bits, unsigned.
  - For the defaults this is (y<<7)+(y<<5)+x; the maximum is 19199.
  - The FIFO stores {addr, colour}, 18 bits per entry.
- FIFO: DEPTH entries, circular read/write pointers, occupancy counter 0..DEPTH.
  - Push and pop in the same cycle when neither full nor empty leaves occupancy unchanged.
- Output stage FSM:
  - State EMPTY: fb_wr_en=0. If the FIFO is non-empty, pop the head into the output register and go to WRITE.
  - State WRITE: fb_wr_en=1; fb_addr and fb_data hold the registered entry.
    - If fb_busy=0 and the FIFO is non-empty, pop the next entry and stay in WRITE.
    - If fb_busy=0 and the FIFO is empty, go to EMPTY.
    - If fb_busy=1, hold all outputs stable.
- idle = (state==EMPTY) && (occupancy==0).
- Reset, asynchronous and including mid-operation:
  - Pointers and occupancy go to 0; state goes to EMPTY.
  - fb_wr_en=0, fb_addr=0, fb_data=0, drop_count=0.
  - plot_ready=1, idle=1.
  - Pending and buffered writes are discarded.

## Timing
- Latency: a request accepted at edge N into an empty sink drives fb_wr_en=1 from edge N+1. This is one cycle in the FIFO, then the output register.
- Throughput: one write per cycle while fb_busy=0 and requests keep arriving.
- Rejected (off-screen) requests cost one accept cycle and produce no write. drop_count updates at the accepting edge.
- While fb_busy=1, fb_addr and fb_data must not change. The FIFO fills and plot_ready falls when occupancy reaches DEPTH.
- idle rises at the edge after the last write completes.

## Test plan
- Single plot x=3, y=2, colour=5, fb_busy=0 -> fb_wr_en high for exactly one cycle, starting the cycle after accept; fb_addr=323, fb_data=5; then idle=1.
- Corners (0,0), (159,119), and wrap neighbours (159,0)/(0,1) -> addresses 0, 19199, 159, 160, in order.
- Off-screen x=160,y=0 then x=0,y=120 -> no fb_wr_en, drop_count=2. Then 300 off-screen requests -> drop_count=255, held.
- fb_busy held 1 while 6 requests are offered -> 4 entries plus the output register accepted; plot_ready=0 with the 6th pending; fb_addr stable. Release fb_busy -> all 5 accepted writes plus the 6th emerge in order, one per cycle.
- Back-to-back stream of 20 plots with fb_busy=0 -> 20 consecutive fb_wr_en cycles; plot_ready never drops.
- Assert reset low with 3 entries buffered and fb_busy=1 -> fb_wr_en=0 immediately, idle=1, plot_ready=1 after release, no stale writes afterwards.
